interrupt_test_sequencer: RTL and testbench
===========================================

Name: interrupt_test_sequencer

Overview:
- Downstream controller for the interrupt checker state machine; drives its START and consumes its BUSY, INTERRUPT_INIT_STATE and INTERRUPT_TRANSITION.
- Runs one interrupt test per request:
  - arms the checker;
  - waits a programmable observation window;
  - compares the captured init state and transition flag against expected values;
  - reports pass/fail with a reason code and keeps saturating pass/fail tallies for the test software.

Parameters:
- WINDOW_W, 16, width of the observation-window cycle count.
- CNT_W, 8, width of the pass and fail tally counters.
- HS_TIMEOUT, 8, max cycles in WAIT_CHK before a handshake-timeout fail; legal range 4..255.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high, sampled on the CLK rising edge.
- TEST_START  in  1  request one test; sampled only in IDLE.
- WINDOW_CYCLES  in  WINDOW_W  observation window length, sampled in ARM.
- EXPECT_INIT_STATE  in  1  expected INTERRUPT_BAR level at arm time; sampled in ARM.
- EXPECT_TRANSITION  in  1  1 = a falling edge must occur during the test; sampled in ARM.
- CHK_START  out  1  to the checker START.
- CHK_BUSY  in  1  from the checker BUSY.
- CHK_INIT_STATE  in  1  from the checker INTERRUPT_INIT_STATE.
- CHK_TRANSITION  in  1  from the checker INTERRUPT_TRANSITION.
- TEST_BUSY  out  1  high in every state except IDLE.
- TEST_DONE  out  1  one-cycle pulse when a result is valid.
- TEST_PASS  out  1  result of the last test, held until the next TEST_DONE.
- FAIL_CODE  out  2  reason code: 0 pass, 1 init mismatch, 2 transition mismatch, 3 handshake timeout; held.
- PASS_COUNT  out  CNT_W  saturating count of passed tests.
- FAIL_COUNT  out  CNT_W  saturating count of failed tests.

Behaviour:
- Reset: state IDLE. Every output is 0, counters are 0, latched expectations are 0. Reset in any state aborts the test with no TEST_DONE and clears the tallies.
- States and transitions (each state lasts at least one cycle):
  - IDLE: TEST_START=1 -> ARM. Otherwise stay.
  - ARM: exactly one cycle. CHK_START=1 only in this state. Latch WINDOW_CYCLES, EXPECT_INIT_STATE and EXPECT_TRANSITION. Clear the seen_busy flag and the handshake counter. -> WAIT_CHK.
  - WAIT_CHK:
    - Set seen_busy when CHK_BUSY=1.
    - If seen_busy=1 and CHK_BUSY=0 -> WINDOW. The checker has then latched its init state and cleared its transition flag.
    - The handshake counter increments every cycle. When it reaches HS_TIMEOUT-1 without completion -> EVAL with forced FAIL_CODE=3.
  - WINDOW:
    - Down-counter loaded with the latched window length on entry. Exit -> EVAL on the cycle the counter reads 0.
    - WINDOW_CYCLES=0 gives one WINDOW cycle. WINDOW_CYCLES=N gives N+1 WINDOW cycles.
  - EVAL: one cycle.
    - Compute the result from CHK_INIT_STATE and CHK_TRANSITION as sampled in this cycle.
    - Register TEST_PASS and FAIL_CODE.
    - Pulse TEST_DONE on the following cycle (registered), coincident with the return to IDLE.
- Fail priority: timeout (3) > init mismatch (1) > transition mismatch (2). TEST_PASS=1 if and only if FAIL_CODE=0.
- Tallies:
  - PASS_COUNT or FAIL_COUNT increments by 1 on the TEST_DONE cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
- TEST_START while TEST_BUSY=1 is ignored. TEST_START held high starts back-to-back tests; the next test arms on the cycle after TEST_DONE.
- CHK_TRANSITION is a sticky input. A falling edge anywhere from the checker's clear cycle to EVAL counts.
- Nominal latency with a compliant checker, TEST_START edge to TEST_DONE: WINDOW_CYCLES + 7 cycles. Breakdown:
  - IDLE sample: 1
  - ARM: 1
  - WAIT_CHK: 3 (checker BUSY rises 1 cycle after START, is high for 2 cycles)
  - WINDOW: WINDOW_CYCLES + 1
  - EVAL: 1

Optional Feature:
- Macro: INTSEQ_EARLY_EXIT_EN.
- Defined: in WINDOW, CHK_TRANSITION=1 with EXPECT_TRANSITION=1 exits to EVAL on the next edge without waiting for the counter, shortening passing tests. All other window behaviour is unchanged.
- Undefined: the window always runs its full length.

Test Plan:
- WINDOW_CYCLES=10, EXPECT_INIT_STATE=1, EXPECT_TRANSITION=0, INTERRUPT_BAR held 1 -> TEST_DONE 17 cycles after TEST_START; TEST_PASS=1, FAIL_CODE=0, PASS_COUNT=1.
- Same setup, INTERRUPT_BAR driven 1->0 at window cycle 5 -> TEST_PASS=0, FAIL_CODE=2, FAIL_COUNT=1. With INTSEQ_EARLY_EXIT_EN defined and EXPECT_TRANSITION=1 -> TEST_PASS=1, and TEST_DONE comes earlier than 17 cycles.
- EXPECT_INIT_STATE=1 with INTERRUPT_BAR held 0 and EXPECT_TRANSITION=1 with no edge -> FAIL_CODE=1 (init outranks transition).
- CHK_BUSY tied 0 (checker stub), HS_TIMEOUT=8 -> WAIT_CHK lasts 8 cycles, FAIL_CODE=3, TEST_DONE asserts once.
- CNT_W=2, 5 consecutive passing tests with TEST_START held high -> PASS_COUNT saturates at 3. A TEST_START pulse mid-test has no effect. RST asserted in WINDOW -> next cycle IDLE, no TEST_DONE, counts 0.

Source files
------------

// File: rtl/interrupt_test_sequencer.sv
// rtl/interrupt_test_sequencer.sv - arms the interrupt checker, waits a window, grades the result.
// Optional INTSEQ_EARLY_EXIT_EN: leave the window as soon as an expected transition is seen.
module interrupt_test_sequencer #(
    parameter int WINDOW_W   = 16,
    parameter int CNT_W      = 8,
    parameter int HS_TIMEOUT = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TEST_START,
    input  logic [WINDOW_W-1:0] WINDOW_CYCLES,
    input  logic                EXPECT_INIT_STATE,
    input  logic                EXPECT_TRANSITION,
    output logic                CHK_START,
    input  logic                CHK_BUSY,
    input  logic                CHK_INIT_STATE,
    input  logic                CHK_TRANSITION,
    output logic                TEST_BUSY,
    output logic                TEST_DONE,
    output logic                TEST_PASS,
    output logic [1:0]          FAIL_CODE,
    output logic [CNT_W-1:0]    PASS_COUNT,
    output logic [CNT_W-1:0]    FAIL_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_CHK,
        S_WINDOW,
        S_EVAL
    } state_t;

    localparam logic [7:0] HS_LAST = 8'(HS_TIMEOUT - 1);

    state_t              state;
    state_t              state_d;
    logic [WINDOW_W-1:0] win_len;
    logic [WINDOW_W-1:0] win_cnt;
    logic                exp_init;
    logic                exp_trans;
    logic                seen_busy;
    logic [7:0]          hs_cnt;
    logic                timed_out;
    logic                hs_expired;
    logic [1:0]          eval_code;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        hs_expired = 1'b0;
        case (state)
            S_IDLE: begin
                if (TEST_START) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                state_d = S_WAIT_CHK;
            end
            S_WAIT_CHK: begin
                // Completion wins over a timeout landing on the same cycle.
                if (seen_busy && !CHK_BUSY) begin
                    state_d = S_WINDOW;
                end else if (hs_cnt == HS_LAST) begin
                    state_d    = S_EVAL;
                    hs_expired = 1'b1;
                end
            end
            S_WINDOW: begin
                if (win_cnt == '0) begin
                    state_d = S_EVAL;
                end
`ifdef INTSEQ_EARLY_EXIT_EN
                else if (CHK_TRANSITION && exp_trans) begin
                    state_d = S_EVAL;
                end
`endif
            end
            S_EVAL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        eval_code = 2'd0;
        if (timed_out) begin
            eval_code = 2'd3;
        end else if (CHK_INIT_STATE != exp_init) begin
            eval_code = 2'd1;
        end else if (CHK_TRANSITION != exp_trans) begin
            eval_code = 2'd2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win_len    <= '0;
            win_cnt    <= '0;
            exp_init   <= 1'b0;
            exp_trans  <= 1'b0;
            seen_busy  <= 1'b0;
            hs_cnt     <= 8'd0;
            timed_out  <= 1'b0;
            TEST_DONE  <= 1'b0;
            TEST_PASS  <= 1'b0;
            FAIL_CODE  <= 2'd0;
            PASS_COUNT <= '0;
            FAIL_COUNT <= '0;
        end else begin
            TEST_DONE <= 1'b0;
            case (state)
                S_ARM: begin
                    win_len   <= WINDOW_CYCLES;
                    exp_init  <= EXPECT_INIT_STATE;
                    exp_trans <= EXPECT_TRANSITION;
                    seen_busy <= 1'b0;
                    hs_cnt    <= 8'd0;
                    timed_out <= 1'b0;
                end
                S_WAIT_CHK: begin
                    if (CHK_BUSY) begin
                        seen_busy <= 1'b1;
                    end
                    hs_cnt <= hs_cnt + 8'd1;
                    if (hs_expired) begin
                        timed_out <= 1'b1;
                    end
                    if (state_d == S_WINDOW) begin
                        win_cnt <= win_len;
                    end
                end
                S_WINDOW: begin
                    if (win_cnt != '0) begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                S_EVAL: begin
                    // Tallies move on the same edge that raises TEST_DONE.
                    TEST_DONE <= 1'b1;
                    TEST_PASS <= (eval_code == 2'd0);
                    FAIL_CODE <= eval_code;
                    if (eval_code == 2'd0) begin
                        if (PASS_COUNT != '1) begin
                            PASS_COUNT <= PASS_COUNT + 1'b1;
                        end
                    end else if (FAIL_COUNT != '1) begin
                        FAIL_COUNT <= FAIL_COUNT + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CHK_START = (state == S_ARM);
    assign TEST_BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_interrupt_test_sequencer.sv
// tb/tb_interrupt_test_sequencer.sv - directed bench with a behavioural interrupt checker.
module tb_interrupt_test_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TEST_START = 1'b0;
    logic [15:0] WINDOW_CYCLES = 16'd0;
    logic        EXPECT_INIT_STATE = 1'b0;
    logic        EXPECT_TRANSITION = 1'b0;
    logic        CHK_START;
    logic        CHK_BUSY;
    logic        CHK_INIT_STATE;
    logic        CHK_TRANSITION;
    logic        TEST_BUSY;
    logic        TEST_DONE;
    logic        TEST_PASS;
    logic [1:0]  FAIL_CODE;
    logic [1:0]  PASS_COUNT;
    logic [1:0]  FAIL_COUNT;

    logic int_bar = 1'b1;
    logic stub = 1'b0;
    logic busy_m, init_m, trans_m, bar_d;
    logic [1:0] cnt_m;

    int n_checks = 0;
    int n_pass = 0;
    int lat;

    interrupt_test_sequencer #(.WINDOW_W(16), .CNT_W(2), .HS_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .TEST_START(TEST_START), .WINDOW_CYCLES(WINDOW_CYCLES),
        .EXPECT_INIT_STATE(EXPECT_INIT_STATE), .EXPECT_TRANSITION(EXPECT_TRANSITION),
        .CHK_START(CHK_START), .CHK_BUSY(CHK_BUSY), .CHK_INIT_STATE(CHK_INIT_STATE),
        .CHK_TRANSITION(CHK_TRANSITION), .TEST_BUSY(TEST_BUSY), .TEST_DONE(TEST_DONE),
        .TEST_PASS(TEST_PASS), .FAIL_CODE(FAIL_CODE), .PASS_COUNT(PASS_COUNT),
        .FAIL_COUNT(FAIL_COUNT)
    );

    always #5 CLK = ~CLK;

    // Checker: BUSY for 2 cycles after START, latches level and clears the flag as BUSY drops.
    always @(posedge CLK) begin
        bar_d <= int_bar;
        if (RST) begin
            busy_m <= 1'b0; cnt_m <= 2'd0; init_m <= 1'b0; trans_m <= 1'b0;
        end else if (CHK_START && !busy_m) begin
            busy_m <= 1'b1; cnt_m <= 2'd1;
        end else if (busy_m) begin
            if (cnt_m == 2'd0) begin
                busy_m <= 1'b0; init_m <= int_bar; trans_m <= 1'b0;
            end else begin
                cnt_m <= cnt_m - 2'd1;
            end
        end else if (bar_d && !int_bar) begin
            trans_m <= 1'b1;
        end
    end

    assign CHK_BUSY       = stub ? 1'b0 : busy_m;
    assign CHK_INIT_STATE = init_m;
    assign CHK_TRANSITION = trans_m;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic run_test(input int w, input bit ei, input bit et, input int fall_at,
                            input int pulse_at, output int latency);
        @(negedge CLK);
        WINDOW_CYCLES = 16'(w);
        EXPECT_INIT_STATE = ei;
        EXPECT_TRANSITION = et;
        TEST_START = 1'b1;
        latency = -1;
        for (int k = 1; k <= 200 && latency < 0; k++) begin
            @(negedge CLK);
            TEST_START = (k == pulse_at);
            if (k == fall_at) int_bar = 1'b0;
            if (TEST_DONE) latency = k;
        end
        TEST_START = 1'b0;
        if (latency < 0) check("done_seen", 0, 1);
    endtask

    initial begin
        int dones, first_k, last_k;
        repeat (3) @(negedge CLK);
        check("rst_busy", TEST_BUSY, 0);
        check("rst_done", TEST_DONE, 0);
        check("rst_pass", TEST_PASS, 0);
        check("rst_code", FAIL_CODE, 0);
        check("rst_pcnt", PASS_COUNT, 0);
        check("rst_fcnt", FAIL_COUNT, 0);
        check("rst_start", CHK_START, 0);
        RST = 1'b0;

        run_test(10, 1, 0, 0, 0, lat);
        check("a_lat", lat, 17);
        check("a_pass", TEST_PASS, 1);
        check("a_code", FAIL_CODE, 0);
        check("a_pcnt", PASS_COUNT, 1);
        check("a_fcnt", FAIL_COUNT, 0);
        @(negedge CLK);
        check("a_done_pulse", TEST_DONE, 0);

        run_test(10, 1, 0, 9, 0, lat);
        check("b_lat", lat, 17);
        check("b_pass", TEST_PASS, 0);
        check("b_code", FAIL_CODE, 2);
        check("b_fcnt", FAIL_COUNT, 1);
        int_bar = 1'b1;

        run_test(10, 1, 1, 9, 0, lat);
`ifdef INTSEQ_EARLY_EXIT_EN
        check("c_lat", lat, 12);
`else
        check("c_lat", lat, 17);
`endif
        check("c_pass", TEST_PASS, 1);
        check("c_code", FAIL_CODE, 0);
        check("c_pcnt", PASS_COUNT, 2);
        int_bar = 1'b1;

        int_bar = 1'b0;
        run_test(4, 1, 1, 0, 0, lat);
        check("d_lat", lat, 11);
        check("d_code", FAIL_CODE, 1);
        check("d_fcnt", FAIL_COUNT, 2);
        int_bar = 1'b1;

        stub = 1'b1;
        run_test(3, 1, 0, 0, 0, lat);
        check("e_lat", lat, 11);
        check("e_code", FAIL_CODE, 3);
        check("e_pass", TEST_PASS, 0);
        check("e_fcnt", FAIL_COUNT, 3);
        dones = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TEST_DONE) dones++;
        end
        check("e_single_done", dones, 0);
        check("e_idle", TEST_BUSY, 0);
        stub = 1'b0;

        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        WINDOW_CYCLES = 16'd0;
        EXPECT_INIT_STATE = 1'b1;
        EXPECT_TRANSITION = 1'b0;
        TEST_START = 1'b1;
        dones = 0; first_k = 0; last_k = 0;
        for (int k = 1; k <= 100 && dones < 5; k++) begin
            @(negedge CLK);
            if (dones >= 4) TEST_START = 1'b0;
            if (TEST_DONE) begin
                dones++;
                if (dones == 1) first_k = k;
                last_k = k;
            end
        end
        TEST_START = 1'b0;
        check("s_dones", dones, 5);
        check("s_first", first_k, 7);
        check("s_period", last_k - first_k, 28);
        check("s_pcnt_sat", PASS_COUNT, 3);
        check("s_fcnt", FAIL_COUNT, 0);
        repeat (2) @(negedge CLK);
        check("s_idle", TEST_BUSY, 0);

        run_test(10, 1, 0, 0, 6, lat);
        check("p_lat", lat, 17);
        check("p_pcnt", PASS_COUNT, 3);
        @(negedge CLK);
        check("p_busy1", TEST_BUSY, 0);
        @(negedge CLK);
        check("p_busy2", TEST_BUSY, 0);

        @(negedge CLK);
        WINDOW_CYCLES = 16'd10;
        TEST_START = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            TEST_START = 1'b0;
        end
        check("r_in_window", TEST_BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("r_busy", TEST_BUSY, 0);
        check("r_done", TEST_DONE, 0);
        check("r_pcnt", PASS_COUNT, 0);
        check("r_fcnt", FAIL_COUNT, 0);
        dones = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TEST_DONE) dones++;
        end
        check("r_no_done", dones, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
